// File: rtl/skf_pkg.sv
// Shared definitions for the Skolem-formula enumeration scanner and any
// checker-side blocks that must agree on the assignment width.
//   SKF_N_VARS  : default number of variables (assignment vector width)
//   skf_state_e : scanner FSM states
package skf_pkg;

    localparam int SKF_N_VARS = 13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } skf_state_e;

endpackage

// File: rtl/skf_hit_accum.sv
// Hit accumulator for the enumeration scanner: counts satisfying probes and
// captures the first (lowest) satisfying assignment of a scan.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   clr_i         : clear all results (start of a new scan)
//   smp_i         : this cycle's probe is valid and must be sampled
//   res_i         : checker verdict for vec_i
//   vec_i         : assignment being probed
//   hit_cnt_o     : number of sampled probes with res_i=1
//   found_o       : at least one hit since the last clear
//   first_hit_o   : assignment of the first hit, 0 if none
module skf_hit_accum
    import skf_pkg::*;
#(
    parameter int N_VARS = SKF_N_VARS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              smp_i,
    input  logic              res_i,
    input  logic [N_VARS-1:0] vec_i,
    output logic [N_VARS:0]   hit_cnt_o,
    output logic              found_o,
    output logic [N_VARS-1:0] first_hit_o
);

    logic [N_VARS:0]   hit_cnt_q;
    logic              found_q;
    logic [N_VARS-1:0] first_hit_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            hit_cnt_q   <= '0;
            found_q     <= 1'b0;
            first_hit_q <= '0;
        end else if (smp_i && res_i) begin
            hit_cnt_q <= hit_cnt_q + (N_VARS+1)'(1);
            // Probes ascend, so the first hit is also the lowest one.
            if (!found_q) begin
                found_q     <= 1'b1;
                first_hit_q <= vec_i;
            end
        end
    end

    assign hit_cnt_o   = hit_cnt_q;
    assign found_o     = found_q;
    assign first_hit_o = first_hit_q;

endmodule

// File: rtl/skf_enum_scanner.sv
// Exhaustive assignment enumerator for a combinational Skolem-formula
// checker. On start it drives every assignment 0 .. 2^N_VARS-1, one per
// cycle, samples the checker verdict and reports hit statistics.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start_i      : request a scan (accepted in IDLE only)
//   abort_i      : terminate an active scan; current probe is discarded
//   vec_o        : current assignment (0 when not probing)
//   vec_vld_o    : vec_o is a live probe
//   res_i        : checker verdict for vec_o, same cycle
//   busy_o       : scan in progress
//   done_o       : one-cycle completion/abort pulse
//   hit_cnt_o    : satisfying probes in the last scan
//   found_o      : at least one hit in the last scan
//   first_hit_o  : lowest satisfying assignment, 0 if none
//   aborted_o    : last scan ended by abort_i
module skf_enum_scanner
    import skf_pkg::*;
#(
    parameter int N_VARS      = SKF_N_VARS,
    parameter int STOP_ON_HIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    output logic [N_VARS-1:0] vec_o,
    output logic              vec_vld_o,
    input  logic              res_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [N_VARS:0]   hit_cnt_o,
    output logic              found_o,
    output logic [N_VARS-1:0] first_hit_o,
    output logic              aborted_o
);

    skf_state_e        state_q, state_d;
    logic [N_VARS-1:0] vec_q, vec_d;
    logic              aborted_q, aborted_d;
    logic              clr;
    logic              smp;
    logic              last_vec;

    assign last_vec = (vec_q == {N_VARS{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            vec_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        aborted_d = aborted_q;
        clr       = 1'b0;
        smp       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d   = ST_SCAN;
                    vec_d     = '0;
                    aborted_d = 1'b0;
                    clr       = 1'b1;
                end
            end
            ST_SCAN: begin
                if (abort_i) begin
                    // Abort beats the probe, including the terminal one.
                    aborted_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    smp = 1'b1;
                    // Stop after the all-ones probe rather than wrapping.
                    if (last_vec || ((STOP_ON_HIT != 0) && res_i)) begin
                        state_d = ST_DONE;
                    end else begin
                        vec_d = vec_q + N_VARS'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    skf_hit_accum #(
        .N_VARS (N_VARS)
    ) u_accum (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (clr),
        .smp_i       (smp),
        .res_i       (res_i),
        .vec_i       (vec_q),
        .hit_cnt_o   (hit_cnt_o),
        .found_o     (found_o),
        .first_hit_o (first_hit_o)
    );

    // All outputs come from registers; res_i only reaches state.
    assign busy_o    = (state_q == ST_SCAN);
    assign vec_vld_o = busy_o;
    assign vec_o     = busy_o ? vec_q : '0;
    assign done_o    = (state_q == ST_DONE);
    assign aborted_o = aborted_q;

endmodule

// File: tb/tb_skf_enum_scanner.sv
module tb_skf_enum_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // N_VARS=3, STOP_ON_HIT=0
    logic       start3, abort3, res3, vld3, busy3, done3, found3, abt3;
    logic [2:0] vec3, first3;
    logic [3:0] hit3;
    // N_VARS=3, STOP_ON_HIT=1
    logic       starts, aborts, ress, vlds, busys, dones, founds, abts;
    logic [2:0] vecs, firsts;
    logic [3:0] hits;
    // N_VARS=13
    logic        start13, abort13, res13, vld13, busy13, done13, found13, abt13;
    logic [12:0] vec13, first13;
    logic [13:0] hit13;

    int mode3, modes;

    int errors = 0;
    int checks = 0;

    function automatic logic fres(input int m, input int v);
        case (m)
            1:       return v == 5;
            2:       return 1'b1;
            3:       return v >= 2;
            4:       return (v == 0) || (v == 7);
            5:       return (v % 2) == 1;
            default: return 1'b0;
        endcase
    endfunction

    always_comb res3 = fres(mode3, int'(vec3));
    always_comb ress = fres(modes, int'(vecs));
    assign res13 = 1'b1;

    skf_enum_scanner #(.N_VARS(3), .STOP_ON_HIT(0)) dut3 (
        .clk(clk), .rst(rst), .start_i(start3), .abort_i(abort3),
        .vec_o(vec3), .vec_vld_o(vld3), .res_i(res3), .busy_o(busy3),
        .done_o(done3), .hit_cnt_o(hit3), .found_o(found3),
        .first_hit_o(first3), .aborted_o(abt3));

    skf_enum_scanner #(.N_VARS(3), .STOP_ON_HIT(1)) dut3s (
        .clk(clk), .rst(rst), .start_i(starts), .abort_i(aborts),
        .vec_o(vecs), .vec_vld_o(vlds), .res_i(ress), .busy_o(busys),
        .done_o(dones), .hit_cnt_o(hits), .found_o(founds),
        .first_hit_o(firsts), .aborted_o(abts));

    skf_enum_scanner #(.N_VARS(13), .STOP_ON_HIT(0)) dut13 (
        .clk(clk), .rst(rst), .start_i(start13), .abort_i(abort13),
        .vec_o(vec13), .vec_vld_o(vld13), .res_i(res13), .busy_o(busy13),
        .done_o(done13), .hit_cnt_o(hit13), .found_o(found13),
        .first_hit_o(first13), .aborted_o(abt13));

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full scan on dut3: checks probe order, latency and results.
    task automatic run3(input string tag, input int m, input int exp_hit,
                        input int exp_found, input int exp_first);
        int cyc, probes, bad_seq;
        mode3 = m;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        cyc = 1; probes = 0; bad_seq = 0;
        while (!done3 && cyc < 40) begin
            if (vld3) begin
                if (int'(vec3) != probes) bad_seq++;
                probes++;
            end
            tick();
            cyc++;
        end
        chk({tag, "_done_cycle"}, cyc, 9);
        chk({tag, "_probes"}, probes, 8);
        chk({tag, "_probe_order"}, bad_seq, 0);
        chk({tag, "_hit_cnt"}, int'(hit3), exp_hit);
        chk({tag, "_found"}, int'(found3), exp_found);
        chk({tag, "_first_hit"}, int'(first3), exp_first);
        chk({tag, "_busy_at_done"}, int'(busy3), 0);
        tick();
        chk({tag, "_done_one_cycle"}, int'(done3), 0);
        chk({tag, "_hit_hold"}, int'(hit3), exp_hit);
        $display("scan %s: cycles=%0d probes=%0d hit_cnt=%0d found=%0d first=%0d",
                 tag, cyc, probes, hit3, found3, first3);
    endtask

    typedef struct {
        string name;
        int    mode;
        int    hit;
        int    found;
        int    first;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int cyc, cnt, lastv;

        tbl[0] = '{"eq5",   1, 1, 1, 5};
        tbl[1] = '{"all1",  2, 8, 1, 0};
        tbl[2] = '{"none",  0, 0, 0, 0};
        tbl[3] = '{"ends",  4, 2, 1, 0};
        tbl[4] = '{"odd",   5, 4, 1, 1};

        rst = 1'b1;
        start3 = 0; abort3 = 0; starts = 0; aborts = 0; start13 = 0; abort13 = 0;
        mode3 = 0; modes = 0;
        tick();
        tick();
        chk("rst_vec", int'(vec3), 0);
        chk("rst_vld", int'(vld3), 0);
        chk("rst_busy", int'(busy3), 0);
        chk("rst_done", int'(done3), 0);
        chk("rst_hit", int'(hit3), 0);
        chk("rst_found", int'(found3), 0);
        chk("rst_first", int'(first3), 0);
        chk("rst_aborted", int'(abt3), 0);
        $display("reset: vec=%0d busy=%0d hit=%0d", vec3, busy3, hit3);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            run3(tbl[i].name, tbl[i].mode, tbl[i].hit, tbl[i].found, tbl[i].first);
        end

        // STOP_ON_HIT with res=(vec>=2)
        modes = 3;
        starts = 1'b1;
        tick();
        starts = 1'b0;
        cyc = 1; lastv = -1;
        while (!dones && cyc < 40) begin
            if (vlds) lastv = int'(vecs);
            tick();
            cyc++;
        end
        chk("stop_done_cycle", cyc, 4);
        chk("stop_last_probe", lastv, 2);
        chk("stop_hit_cnt", int'(hits), 1);
        chk("stop_first_hit", int'(firsts), 2);
        chk("stop_found", int'(founds), 1);
        $display("stop_on_hit: cycles=%0d last=%0d hit=%0d first=%0d", cyc, lastv, hits, firsts);
        tick();

        // Abort on the terminal probe, res always 1
        mode3 = 2;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        cyc = 1;
        while (!(vld3 && vec3 == 3'd7) && cyc < 40) begin
            tick();
            cyc++;
        end
        abort3 = 1'b1;
        tick();
        abort3 = 1'b0;
        chk("abort_done", int'(done3), 1);
        chk("abort_flag", int'(abt3), 1);
        chk("abort_hit_cnt", int'(hit3), 7);
        chk("abort_first", int'(first3), 0);
        chk("abort_busy", int'(busy3), 0);
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done3) cnt++;
        end
        chk("abort_single_done", cnt, 0);
        abort3 = 1'b1;
        tick();
        abort3 = 1'b0;
        chk("idle_abort_busy", int'(busy3), 0);
        chk("idle_abort_done", int'(done3), 0);
        chk("idle_abort_hold", int'(hit3), 7);
        $display("abort: aborted=%0d hit=%0d", abt3, hit3);

        // Reset in the middle of a scan
        mode3 = 1;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        cyc = 1;
        while (!(vld3 && vec3 == 3'd4) && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("pre_rst_found", int'(found3), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_vec", int'(vec3), 0);
        chk("mid_rst_vld", int'(vld3), 0);
        chk("mid_rst_busy", int'(busy3), 0);
        chk("mid_rst_done", int'(done3), 0);
        chk("mid_rst_hit", int'(hit3), 0);
        chk("mid_rst_found", int'(found3), 0);
        chk("mid_rst_first", int'(first3), 0);
        chk("mid_rst_aborted", int'(abt3), 0);
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done3 || busy3) cnt++;
        end
        chk("mid_rst_quiet", cnt, 0);
        $display("mid_scan_reset: vec=%0d hit=%0d", vec3, hit3);
        run3("after_rst", 1, 1, 1, 5);

        // start held high across the whole scan
        mode3 = 0;
        start3 = 1'b1;
        tick();
        cyc = 1; cnt = 0;
        while (!done3 && cyc < 40) begin
            if (vld3) cnt++;
            tick();
            cyc++;
        end
        chk("held_start_probes", cnt, 8);
        chk("held_start_cycle", cyc, 9);
        tick();
        start3 = 1'b0;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (busy3 || done3) cnt++;
        end
        chk("held_start_single_scan", cnt, 0);
        $display("held_start: done_cycle=%0d", cyc);

        // N_VARS=13 full scan, every probe a hit
        start13 = 1'b1;
        tick();
        start13 = 1'b0;
        cyc = 1; cnt = 0;
        while (!done13 && cyc < 9000) begin
            if (vld13) cnt++;
            tick();
            cyc++;
        end
        chk("n13_done_cycle", cyc, 8193);
        chk("n13_probes", cnt, 8192);
        chk("n13_hit_cnt", int'(hit13), 8192);
        chk("n13_found", int'(found13), 1);
        chk("n13_first", int'(first13), 0);
        $display("n13: cycles=%0d hit=%0d", cyc, hit13);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
